// File: rtl/flux_merge_arb.sv
// flux_merge_arb
// Merges FLUX independent untagged payload streams into one tagged write
// stream for a downstream multi-flux FIFO. Each stream is buffered in its own
// DEPTH-entry queue. A round-robin arbiter picks among the streams that have
// data and downstream room. Each grant emits one {tag, payload} word with a
// single-cycle wr strobe.
//
// Ports:
//   ck       clock, rising edge
//   rst      synchronous active-high reset
//   in_wr    per-flux write strobe
//   in_data  per-flux payload, flux i at [i*PW +: PW]
//   in_full  per-flux input queue full
//   dn_full  per-flux downstream full (from downstream registered state)
//   wr       registered downstream write strobe
//   dataout  registered {tag, payload}, valid while wr=1
//   idle     all input queues empty and no word being presented
module flux_merge_arb #(
  parameter  int WIDTH     = 8,
  parameter  int DEPTH     = 4,
  parameter  int FLUX      = 2,
  localparam int TAG_WIDTH = $clog2(FLUX),
  localparam int PW        = WIDTH - TAG_WIDTH
) (
  input  logic                 ck,
  input  logic                 rst,
  input  logic [FLUX-1:0]      in_wr,
  input  logic [FLUX*PW-1:0]   in_data,
  output logic [FLUX-1:0]      in_full,
  input  logic [FLUX-1:0]      dn_full,
  output logic                 wr,
  output logic [WIDTH-1:0]     dataout,
  output logic                 idle
);

  localparam int AW   = $clog2(DEPTH);
  localparam int PTRW = AW + 1;

  logic                      r_wr;
  logic [WIDTH-1:0]          r_dataout;
  logic [TAG_WIDTH-1:0]      r_last;

  logic [FLUX-1:0]           w_full;
  logic [FLUX-1:0]           w_empty;
  logic [FLUX-1:0]           w_elig;
  logic [FLUX-1:0]           w_push;
  logic [FLUX-1:0][PW-1:0]   w_head;
  logic [TAG_WIDTH-1:0]      w_inflight_tag;
  logic                      w_grant_valid;
  logic [TAG_WIDTH-1:0]      w_grant;
  logic [TAG_WIDTH-1:0]      w_cand;

  assign w_inflight_tag = r_dataout[WIDTH-1 -: TAG_WIDTH];

  genvar gi;
  generate
    for (gi = 0; gi < FLUX; gi++) begin : g_queue
      logic [PTRW-1:0] r_wp;
      logic [PTRW-1:0] r_rp;
      logic [PW-1:0]   r_mem [DEPTH];
      logic [PTRW-1:0] w_count;
      logic            w_pop;

      // Pointers carry a wrap bit, so the full and empty states are told
      // apart by the difference alone.
      assign w_count     = r_wp - r_rp;
      assign w_full[gi]  = (w_count == PTRW'(DEPTH));
      assign w_empty[gi] = (w_count == '0);
      assign w_head[gi]  = r_mem[r_rp[AW-1:0]];

      // The in-flight guard keeps a flux out of arbitration while its
      // previous word is still on the bus. Downstream full has not yet
      // accounted for that word.
      assign w_elig[gi] = !w_empty[gi] && !dn_full[gi] &&
                          !(r_wr && (w_inflight_tag == TAG_WIDTH'(gi)));

      // Fullness is judged before the edge, so a write to a full queue is
      // lost even when the same edge pops it.
      assign w_push[gi] = in_wr[gi] && !w_full[gi];
      assign w_pop      = w_grant_valid && (w_grant == TAG_WIDTH'(gi));

      always_ff @(posedge ck) begin
        if (rst) begin
          r_wp <= '0;
          r_rp <= '0;
        end else begin
          if (w_push[gi]) begin
            r_wp <= r_wp + 1'b1;
          end
          if (w_pop) begin
            r_rp <= r_rp + 1'b1;
          end
        end
      end

      // Storage needs no reset. The pointers alone decide which entries are live.
      always_ff @(posedge ck) begin
        if (w_push[gi]) begin
          r_mem[r_wp[AW-1:0]] <= in_data[gi*PW +: PW];
        end
      end
    end
  endgenerate

  // Round-robin search that starts one past the last granted flux and wraps
  // at FLUX, so non-power-of-two flux counts never visit unused tags.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant       = '0;
    w_cand        = r_last;
    for (int k = 0; k < FLUX; k++) begin
      w_cand = (w_cand == TAG_WIDTH'(FLUX - 1)) ? '0 : w_cand + 1'b1;
      if (!w_grant_valid && w_elig[w_cand]) begin
        w_grant_valid = 1'b1;
        w_grant       = w_cand;
      end
    end
  end

  // Output register. dataout keeps its old value on idle cycles, and wr
  // alone marks a new word.
  always_ff @(posedge ck) begin
    if (rst) begin
      r_wr      <= 1'b0;
      r_dataout <= '0;
      r_last    <= TAG_WIDTH'(FLUX - 1);
    end else begin
      r_wr <= w_grant_valid;
      if (w_grant_valid) begin
        r_dataout <= {w_grant, w_head[w_grant]};
        r_last    <= w_grant;
      end
    end
  end

  assign wr      = r_wr;
  assign dataout = r_dataout;
  assign in_full = w_full;
  assign idle    = (&w_empty) && !r_wr;

endmodule

// File: doc/flux_merge_arb.md
Name: flux_merge_arb

Overview:
- Transmit-side counterpart of the tagged multi-flux FIFO; produces the single tagged write stream that the FIFO demultiplexes.
- Accepts FLUX independent untagged payload streams and buffers each in a private DEPTH-entry queue.
- Round-robin arbitrates among fluxes that have data and downstream space, then emits one word per grant as {tag, payload} with a wr strobe.
- Consumes the downstream per-flux full vector, so it never issues a write that the downstream queue would drop.

Parameters:
- WIDTH, 8, downstream word width including tag.
- DEPTH, 4, entries per input queue; power of two, >=2.
- FLUX, 2, number of streams; >=2.
- TAG_WIDTH, $clog2(FLUX), derived; tag occupies dataout[WIDTH-1 -: TAG_WIDTH].
- PW, WIDTH-TAG_WIDTH, derived payload width.

Ports:
- ck  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- in_wr  in  FLUX  per-flux write strobe.
- in_data  in  FLUX*PW  payload; flux i occupies bits [i*PW +: PW].
- in_full  out  FLUX  input queue i holds DEPTH entries.
- dn_full  in  FLUX  downstream full per flux; combinational from the downstream's registered state.
- wr  out  1  downstream write strobe, registered.
- dataout  out  WIDTH  {tag, payload}, registered, valid when wr=1.
- idle  out  1  all input queues empty and wr=0.

Behaviour:
- Reset, sampled at the rising edge of ck:
  - wr=0, dataout=0.
  - All queues empty; in_full=0; idle=1.
  - Round-robin pointer last=FLUX-1, so flux 0 has first priority.
- Reset mid-operation discards queued data and any in-flight word. wr is 0 in the cycle after the reset edge.
- Input queues:
  - Each queue uses read and write pointers of $clog2(DEPTH)+1 bits with a wrap bit.
  - count = Wp-Rp. in_full[i] = (count==DEPTH). Empty = (count==0).
  - A write is accepted when in_wr[i]=1 and in_full[i]=0, both evaluated before the edge. A write on a full queue is dropped silently, even if a pop of that queue occurs on the same edge.
  - A simultaneous push and pop on a non-full, non-empty queue leaves count unchanged.
  - Pointers wrap modulo 2*DEPTH.
- Eligibility: flux i is eligible when its queue is non-empty, dn_full[i]=0, and NOT (wr=1 and dataout tag==i).
  - The last condition is the in-flight guard. Downstream full only reflects the pending word one cycle after it is consumed.
  - Consequence: a single active flux issues at most every other cycle.
- Arbitration, every cycle:
  - Search for an eligible flux starting at (last+1) mod FLUX.
  - On a grant g at the edge: pop queue g; wr<=1; dataout<={g[TAG_WIDTH-1:0], head_g}; last<=g.
  - With no eligible flux: wr<=0, dataout holds its previous value, last unchanged.
- Latency: a word written at edge k appears with wr=1 in the cycle following edge k+1, provided it is eligible and wins arbitration at k+1. Per-flux ordering is FIFO.
- wr is asserted for exactly one cycle per word. The downstream always samples a word in the cycle it is presented; there is no stall input.
- Arithmetic: tag comparison uses the low TAG_WIDTH bits of the flux index. Non-power-of-two FLUX leaves the unused tag codes never emitted.
- idle is combinational from the registered state.

Test Plan (WIDTH=8, FLUX=2, DEPTH=4, PW=7):
- Reset; in_wr=2'b10, in_data[13:7]=7'h15 at edge k -> wr=1, dataout=8'h95 in the cycle after edge k+1, for exactly one cycle; idle returns to 1.
- Flux0 loaded with 0x01,0x02,0x03 and flux1 with 0x11,0x12,0x13; dn_full=0 -> six consecutive wr cycles with dataout 01,91,02,92,03,93.
- Only flux0 loaded with 0x0A,0x0B,0x0C -> wr pattern 1,0,1,0,1 with dataout 0A,0B,0C (in-flight guard).
- dn_full=2'b01 held; flux0 holds 0x05; flux1 holds 0x21,0x22 -> only tags 1 (A1, A2) are emitted; after dn_full drops to 0, 0x05 is emitted next.
- dn_full[0]=1; five writes to flux0 with values 1..5 -> in_full[0]=1 after the 4th write and value 5 is dropped; after release exactly 01,02,03,04 are emitted, on alternate cycles.
- Assert rst for one cycle while wr=1 with flux1 holding data -> next cycle wr=0, in_full=0, idle=1; subsequent simultaneous writes to both fluxes are granted flux0 first.
